// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_if
// Description : Rename/CDB/execute-side bundle for the age-ordered issue queue.
// Revision    : 1.0  initial release
// ============================================================================
interface issue_queue_if #(
    parameter int DEPTH = 16,
    parameter int EW    = 89
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          STALL;
    logic          FLUSH;
    logic          alloc_valid;
    logic [EW-1:0] alloc_entry;
    logic [63:0]   busy_in;
    logic          cdb_valid;
    logic [5:0]    cdb_tag;
    logic          exec_ready;
    logic          issue_valid;
    logic [EW-1:0] issue_entry;
    logic          issue_halt;
    logic [CW-1:0] count;

    modport master (
        output STALL, FLUSH, alloc_valid, alloc_entry, busy_in,
               cdb_valid, cdb_tag, exec_ready,
        input  issue_valid, issue_entry, issue_halt, count
    );

    modport slave (
        input  STALL, FLUSH, alloc_valid, alloc_entry, busy_in,
               cdb_valid, cdb_tag, exec_ready,
        output issue_valid, issue_entry, issue_halt, count
    );
endinterface
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue
// Description : Age-ordered, compacting issue queue with CDB wakeup and a
//               single registered output slot toward execute.
// Revision    : 1.0  initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int EW    = 89
) (
    input  logic         CLK,
    input  logic         RESET,
    issue_queue_if.slave bus
);
    localparam int            IW       = $clog2(DEPTH);
    localparam int            CW       = IW + 1;
    localparam logic [CW-1:0] c_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] c_ALMOST = CW'(DEPTH - 1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_rdya;
    logic [DEPTH-1:0] r_rdyb;
    logic [EW-1:0]    r_entry [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [EW-1:0]    r_out_entry;

    // Wakeup-applied view of the array, padded with one empty slot so the
    // compaction shift can always read slot i+1.
    logic [DEPTH:0]   w_wk_valid;
    logic [DEPTH:0]   w_wk_rdya;
    logic [DEPTH:0]   w_wk_rdyb;
    logic [EW-1:0]    w_wk_entry [DEPTH+1];

    logic [DEPTH-1:0] w_elig;
    logic             w_any;
    logic [IW-1:0]    w_sel;
    logic             w_do_issue;
    logic             w_do_alloc;
    logic [CW-1:0]    w_wr_idx;
    logic [CW-1:0]    w_count_nx;
    logic [5:0]       w_new_mapa;
    logic [5:0]       w_new_mapb;
    logic             w_new_rdya;
    logic             w_new_rdyb;

    logic [DEPTH-1:0] w_nx_valid;
    logic [DEPTH-1:0] w_nx_rdya;
    logic [DEPTH-1:0] w_nx_rdyb;
    logic [EW-1:0]    w_nx_entry [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        assign w_wk_valid[gi] = r_valid[gi];
        assign w_wk_entry[gi] = r_entry[gi];
        assign w_wk_rdya[gi]  = r_valid[gi] & (r_rdya[gi] |
                                (bus.cdb_valid & (r_entry[gi][5:0] == bus.cdb_tag)));
        assign w_wk_rdyb[gi]  = r_valid[gi] & (r_rdyb[gi] |
                                (bus.cdb_valid & (r_entry[gi][11:6] == bus.cdb_tag)));
        // Select uses readiness as registered, so a wakeup this cycle issues next cycle.
        assign w_elig[gi]     = r_valid[gi] & r_rdya[gi] & r_rdyb[gi];
    end

    assign w_wk_valid[DEPTH] = 1'b0;
    assign w_wk_rdya[DEPTH]  = 1'b0;
    assign w_wk_rdyb[DEPTH]  = 1'b0;
    assign w_wk_entry[DEPTH] = '0;

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
    end

    assign w_do_issue = w_any & ~bus.STALL & ~bus.FLUSH &
                        (~r_out_valid | bus.exec_ready);
    assign w_do_alloc = bus.alloc_valid & ~bus.STALL & ~bus.FLUSH &
                        (r_count < c_FULL);
    assign w_wr_idx   = r_count - CW'(w_do_issue);
    assign w_count_nx = r_count + CW'(w_do_alloc) - CW'(w_do_issue);

    assign w_new_mapa = bus.alloc_entry[5:0];
    assign w_new_mapb = bus.alloc_entry[11:6];
    assign w_new_rdya = (w_new_mapa == 6'd0) | ~bus.busy_in[w_new_mapa] |
                        (bus.cdb_valid & (bus.cdb_tag == w_new_mapa));
    assign w_new_rdyb = (w_new_mapb == 6'd0) | ~bus.busy_in[w_new_mapb] |
                        (bus.cdb_valid & (bus.cdb_tag == w_new_mapb));

    always_comb begin
        w_nx_valid = '0;
        w_nx_rdya  = '0;
        w_nx_rdyb  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nx_entry[i] = w_wk_entry[i];
            w_nx_valid[i] = w_wk_valid[i];
            w_nx_rdya[i]  = w_wk_rdya[i];
            w_nx_rdyb[i]  = w_wk_rdyb[i];
            if (w_do_issue && (IW'(i) >= w_sel)) begin
                w_nx_entry[i] = w_wk_entry[i+1];
                w_nx_valid[i] = w_wk_valid[i+1];
                w_nx_rdya[i]  = w_wk_rdya[i+1];
                w_nx_rdyb[i]  = w_wk_rdyb[i+1];
            end
            if (w_do_alloc && (CW'(i) == w_wr_idx)) begin
                w_nx_entry[i] = bus.alloc_entry;
                w_nx_valid[i] = 1'b1;
                w_nx_rdya[i]  = w_new_rdya;
                w_nx_rdyb[i]  = w_new_rdyb;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid     <= '0;
            r_rdya      <= '0;
            r_rdyb      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (bus.FLUSH) begin
            r_valid     <= '0;
            r_rdya      <= '0;
            r_rdyb      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Under STALL the next-state view reduces to wakeup only.
            r_valid <= w_nx_valid;
            r_rdya  <= w_nx_rdya;
            r_rdyb  <= w_nx_rdyb;
            r_entry <= w_nx_entry;
            r_count <= w_count_nx;
            if (w_do_issue) begin
                r_out_valid <= 1'b1;
                r_out_entry <= r_entry[w_sel];
            end else if (!bus.STALL && bus.exec_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.issue_valid = r_out_valid;
    assign bus.issue_entry = r_out_entry;
    assign bus.count       = r_count;
    assign bus.issue_halt  = (r_count == c_FULL) |
                             ((r_count == c_ALMOST) & bus.alloc_valid);
endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_queue
// Description : Directed scoreboard bench for issue_queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_issue_queue;
    localparam int DEPTH = 16;
    localparam int EW    = 89;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    issue_queue_if #(.DEPTH(DEPTH), .EW(EW)) bus ();

    issue_queue #(.DEPTH(DEPTH), .EW(EW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int            checks   = 0;
    int            failures = 0;
    logic [EW-1:0] exp_q [$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int id, input logic [5:0] ma, input logic [5:0] mb);
        logic [31:0] v;
        v = 32'(id);
        return {v ^ 32'hA5A5_0000, (v << 2) + 32'h1000, v[6:0], 6'd0, mb, ma};
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: whenever the slot is valid it must show the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET && bus.issue_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got %0h expected none", bus.issue_entry);
                end else begin
                    check("issue_entry", 96'(bus.issue_entry), 96'(exp_q[0]));
                    if (bus.exec_ready && !bus.STALL && !bus.FLUSH)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [EW-1:0] e;
        bus.STALL       = 1'b0;
        bus.FLUSH       = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_entry = '0;
        bus.busy_in     = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.exec_ready  = 1'b1;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", 96'(bus.count), 96'd0);
        check("rst_issue_valid", 96'(bus.issue_valid), 96'd0);
        check("rst_halt", 96'(bus.issue_halt), 96'd0);
        check("rst_issue_entry", 96'(bus.issue_entry), 96'd0);
        RESET = 1'b1;

        // Ready entry issues one cycle after allocate
        e = mk(1, 6'd5, 6'd6);
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = e;
        exp_q.push_back(e);
        cyc();
        bus.alloc_valid = 1'b0;
        check("first_alloc_count", 96'(bus.count), 96'd1);
        check("no_issue_same_edge", 96'(bus.issue_valid), 96'd0);
        cyc();
        check("t1_issue_valid", 96'(bus.issue_valid), 96'd1);
        check("t1_count", 96'(bus.count), 96'd0);
        cyc();
        check("t1_drained", 96'(bus.issue_valid), 96'd0);

        // Younger ready entry bypasses older busy one; wakeup issues one edge later
        bus.busy_in = 64'h200;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(20, 6'd9, 6'd0);
        cyc();
        e = mk(21, 6'd1, 6'd2);
        bus.alloc_entry = e;
        exp_q.push_back(e);
        cyc();
        bus.alloc_valid = 1'b0;
        cyc();
        check("t2_b_issued", 96'(bus.issue_valid), 96'd1);
        check("t2_count", 96'(bus.count), 96'd1);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        exp_q.push_back(mk(20, 6'd9, 6'd0));
        cyc();
        bus.cdb_valid = 1'b0;
        check("t2_a_not_early", 96'(bus.issue_valid), 96'd0);
        check("t2_count_wake", 96'(bus.count), 96'd1);
        cyc();
        check("t2_a_issued", 96'(bus.issue_valid), 96'd1);
        check("t2_count_end", 96'(bus.count), 96'd0);
        cyc();
        bus.busy_in = '0;

        // Fill to DEPTH with busy entries
        bus.busy_in = '1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_entry = mk(300 + i, 6'(32 + i), 6'd0);
            #1;
            check("fill_halt", 96'(bus.issue_halt), 96'(i == DEPTH - 1));
            cyc();
        end
        check("full_count", 96'(bus.count), 96'd16);
        check("full_halt", 96'(bus.issue_halt), 96'd1);
        bus.alloc_entry = mk(999, 6'd0, 6'd0);
        cyc();
        bus.alloc_valid = 1'b0;
        check("overflow_ignored", 96'(bus.count), 96'd16);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd37;
        exp_q.push_back(mk(305, 6'd37, 6'd0));
        cyc();
        bus.cdb_valid = 1'b0;
        check("full_wake_count", 96'(bus.count), 96'd16);
        cyc();
        check("after_issue_count", 96'(bus.count), 96'd15);
        check("after_issue_valid", 96'(bus.issue_valid), 96'd1);
        check("halt_dropped", 96'(bus.issue_halt), 96'd0);
        bus.alloc_valid = 1'b1;
        #1;
        check("halt_almost_alloc", 96'(bus.issue_halt), 96'd1);
        bus.alloc_valid = 1'b0;
        cyc();
        check("full_out_consumed", 96'(bus.issue_valid), 96'd0);
        bus.FLUSH = 1'b1;
        cyc();
        bus.FLUSH = 1'b0;
        check("flush_full_count", 96'(bus.count), 96'd0);
        bus.busy_in = '0;

        // Output slot held while execute is not ready
        bus.exec_ready  = 1'b0;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(40, 6'd3, 6'd4);
        exp_q.push_back(mk(40, 6'd3, 6'd4));
        cyc();
        bus.alloc_entry = mk(41, 6'd7, 6'd8);
        exp_q.push_back(mk(41, 6'd7, 6'd8));
        cyc();
        bus.alloc_valid = 1'b0;
        check("t4_slot_full", 96'(bus.issue_valid), 96'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t4_hold_entry", 96'(bus.issue_entry), 96'(mk(40, 6'd3, 6'd4)));
            check("t4_hold_count", 96'(bus.count), 96'd1);
        end
        bus.exec_ready = 1'b1;
        cyc();
        check("t4_younger", 96'(bus.issue_entry), 96'(mk(41, 6'd7, 6'd8)));
        check("t4_count", 96'(bus.count), 96'd0);
        cyc();

        // Same-cycle CDB hit on allocate
        bus.busy_in     = 64'h1 << 12;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(50, 6'd12, 6'd0);
        bus.cdb_valid   = 1'b1;
        bus.cdb_tag     = 6'd12;
        exp_q.push_back(mk(50, 6'd12, 6'd0));
        cyc();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        check("t5_count", 96'(bus.count), 96'd1);
        cyc();
        check("t5_issued", 96'(bus.issue_valid), 96'd1);
        cyc();

        // STALL blocks allocate and issue but keeps wakeups
        bus.busy_in     = 64'h1 << 40;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(60, 6'd40, 6'd0);
        cyc();
        bus.STALL       = 1'b1;
        bus.cdb_valid   = 1'b1;
        bus.cdb_tag     = 6'd40;
        bus.alloc_entry = mk(61, 6'd0, 6'd0);
        cyc();
        bus.cdb_valid   = 1'b0;
        bus.alloc_valid = 1'b0;
        check("stall_no_alloc", 96'(bus.count), 96'd1);
        check("stall_no_issue", 96'(bus.issue_valid), 96'd0);
        cyc();
        check("stall_no_issue2", 96'(bus.issue_valid), 96'd0);
        bus.STALL = 1'b0;
        exp_q.push_back(mk(60, 6'd40, 6'd0));
        cyc();
        check("stall_wake_kept", 96'(bus.issue_valid), 96'd1);
        cyc();

        // FLUSH with 7 entries and a held output
        bus.busy_in     = '1;
        bus.exec_ready  = 1'b0;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(70, 6'd0, 6'd0);
        exp_q.push_back(mk(70, 6'd0, 6'd0));
        cyc();
        for (int i = 0; i < 7; i++) begin
            bus.alloc_entry = mk(80 + i, 6'd50, 6'd0);
            cyc();
        end
        check("pre_flush_count", 96'(bus.count), 96'd7);
        check("pre_flush_valid", 96'(bus.issue_valid), 96'd1);
        bus.FLUSH = 1'b1;
        cyc();
        bus.FLUSH       = 1'b0;
        bus.alloc_valid = 1'b0;
        check("flush_count", 96'(bus.count), 96'd0);
        check("flush_valid", 96'(bus.issue_valid), 96'd0);
        exp_q.delete();
        bus.busy_in = '0;

        // Asynchronous reset mid-stream
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(90, 6'd0, 6'd0);
        exp_q.push_back(mk(90, 6'd0, 6'd0));
        cyc();
        bus.alloc_entry = mk(91, 6'd0, 6'd0);
        cyc();
        bus.alloc_valid = 1'b0;
        cyc();
        check("pre_rst_count", 96'(bus.count), 96'd1);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_count", 96'(bus.count), 96'd0);
        check("async_rst_valid", 96'(bus.issue_valid), 96'd0);
        check("async_rst_entry", 96'(bus.issue_entry), 96'd0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        bus.exec_ready  = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_entry = mk(95, 6'd2, 6'd3);
        exp_q.push_back(mk(95, 6'd2, 6'd3));
        cyc();
        bus.alloc_valid = 1'b0;
        check("post_rst_alloc", 96'(bus.count), 96'd1);
        cyc();
        check("post_rst_issue", 96'(bus.issue_valid), 96'd1);
        repeat (3) cyc();
        check("scoreboard_empty", 96'(exp_q.size()), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
